ysyx_23060077_rd_arbiter: RTL and testbench
===========================================

# ysyx_23060077_rd_arbiter

Two-master read arbiter between the instruction-cache refill port and the LSU read port, driving the core's single AXI4 read master (AR/R channels). It sits between the IFU's Icache and the SoC bus bridge. It serialises whole read transactions: one request is granted, its address phase and every data beat complete, and only then is the next request granted. Bursts are supported for the Icache; LSU reads are single-beat.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, AXI burst-length width

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low; 0 = reset
- icache_r_valid_i  in  1  Icache read request; held high until the last beat is delivered
- icache_r_addr_i  in  ADDR_W  burst start address
- icache_r_len_i  in  LEN_W  AXI arlen (number of beats − 1)
- icache_r_ready_o  out  1  one-cycle pulse per delivered beat
- icache_r_data_o  out  DATA_W  beat data, valid with ready
- icache_r_last_o  out  1  high with the final beat's ready
- lsu_r_valid_i  in  1  LSU read request; held until ready
- lsu_r_addr_i  in  ADDR_W  read address
- lsu_r_ready_o  out  1  one-cycle pulse with data
- lsu_r_data_o  out  DATA_W  read data
- axi_arvalid_o  out  1
- axi_arready_i  in  1
- axi_araddr_o  out  ADDR_W
- axi_arlen_o  out  LEN_W
- axi_arsize_o  out  3  constant 3'b010
- axi_arburst_o  out  2  constant 2'b01 (INCR)
- axi_rvalid_i  in  1
- axi_rready_o  out  1
- axi_rdata_i  in  DATA_W
- axi_rresp_i  in  2
- axi_rlast_i  in  1
- rd_err_o  out  1  sticky error flag: nonzero rresp, or rlast/beat-count mismatch

## Operation
State machine:
- IDLE: no grant. If any request is valid, select a winner per the arbitration policy, register its address, its len (LSU: 0), and the grant, then go to AR.
- AR: drive axi_arvalid_o=1 from registers. On arready, go to R.
- R: drive axi_rready_o=1. Each rvalid beat:
  - pulse the granted master's ready;
  - drive its data with axi_rdata_i;
  - increment the 8-bit beat counter.
  - On rlast, assert the granted master's last (Icache) and return to IDLE.
- Beat counter clears on entering AR.
- If rlast arrives with count ≠ len, or count reaches len without rlast, set rd_err_o. The FSM still exits only on rlast.
- rresp ≠ 0 on any beat sets rd_err_o. The data is still delivered.
- rd_err_o clears only on reset.
- The non-granted master's ready and last are always 0. Data outputs are combinational pass-through of axi_rdata_i.
- Requests arriving during AR or R wait. A requester must not drop valid before completion; behaviour when it does is undefined.

## Timing
- Reset values:
  - state=IDLE
  - axi_arvalid_o=0, axi_rready_o=0
  - all ready/last outputs=0
  - rd_err_o=0
  - address/len registers=0
  - round-robin pointer=Icache-last (LSU favoured first)
- Reset asserted mid-transaction forces IDLE immediately (asynchronously). arvalid and rready drop in the same cycle.
- Request seen in IDLE at edge N → arvalid high from cycle N+1. arvalid stays stable (address and len unchanged) until arready.
- arready at edge M → rready high from M+1. No combinational path from axi_arready_i to axi_arvalid_o.
- Beat latency is 0: ready/data/last are combinational from rvalid/rdata/rlast while in R.
- After rlast at edge K, the earliest next arvalid is K+2: IDLE at K+1, new AR at K+2.

## Configuration
- YSYX_23060077_ARB_RR_EN defined: round-robin. The master not granted last wins on simultaneous requests; the pointer updates on each grant.
- Undefined: fixed priority, LSU always wins over Icache on simultaneous requests.

## Test plan
- Icache alone, addr 0x3000_0000, len 3, rvalid every cycle, data 0xA0..0xA3:
  - arvalid one cycle after the request, araddr 0x3000_0000, arlen 3;
  - four icache ready pulses carrying 0xA0..0xA3;
  - last on beat 4;
  - rd_err_o stays 0.
- LSU 0x8000_0100 and Icache 0x3000_0040 (len 1) requested on the same cycle:
  - without RR_EN: LSU granted first, arlen 0, then Icache;
  - with RR_EN: LSU then Icache, then on a repeat collision Icache wins.
- arready delayed 5 cycles:
  - arvalid/araddr/arlen held constant for all 5 cycles;
  - rready stays 0 until after the handshake.
- rvalid gaps (beats on cycles 1, 4, 5, 9), len 3: exactly four ready pulses aligned to rvalid; last only on the fourth.
- Error cases, each setting rd_err_o sticky:
  - rresp=2'b10 on beat 2;
  - separately, rlast on beat 2 of a len-3 burst: error set, FSM returns to IDLE.
- Reset low while in R after beat 1: all outputs return to reset values within the same cycle; after reset release with no requests, the FSM stays IDLE.

Source files
------------

// File: rtl/ysyx_23060077_rd_arbiter_if.sv
// Read-side bus bundle around the two-master read arbiter: Icache refill port,
// LSU read port and the single AXI4 AR/R master. The arbiter uses "master", the environment "slave".
interface ysyx_23060077_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              icache_r_valid_i;
    logic [ADDR_W-1:0] icache_r_addr_i;
    logic [LEN_W-1:0]  icache_r_len_i;
    logic              icache_r_ready_o;
    logic [DATA_W-1:0] icache_r_data_o;
    logic              icache_r_last_o;

    logic              lsu_r_valid_i;
    logic [ADDR_W-1:0] lsu_r_addr_i;
    logic              lsu_r_ready_o;
    logic [DATA_W-1:0] lsu_r_data_o;

    logic              axi_arvalid_o;
    logic              axi_arready_i;
    logic [ADDR_W-1:0] axi_araddr_o;
    logic [LEN_W-1:0]  axi_arlen_o;
    logic [2:0]        axi_arsize_o;
    logic [1:0]        axi_arburst_o;
    logic              axi_rvalid_i;
    logic              axi_rready_o;
    logic [DATA_W-1:0] axi_rdata_i;
    logic [1:0]        axi_rresp_i;
    logic              axi_rlast_i;

    logic              rd_err_o;

    modport master (
        input  icache_r_valid_i, icache_r_addr_i, icache_r_len_i,
        output icache_r_ready_o, icache_r_data_o, icache_r_last_o,
        input  lsu_r_valid_i, lsu_r_addr_i,
        output lsu_r_ready_o, lsu_r_data_o,
        output axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
        input  axi_arready_i,
        input  axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
        output axi_rready_o,
        output rd_err_o
    );

    modport slave (
        output icache_r_valid_i, icache_r_addr_i, icache_r_len_i,
        input  icache_r_ready_o, icache_r_data_o, icache_r_last_o,
        output lsu_r_valid_i, lsu_r_addr_i,
        input  lsu_r_ready_o, lsu_r_data_o,
        input  axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
        output axi_arready_i,
        output axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
        input  axi_rready_o,
        input  rd_err_o
    );
endinterface

// File: rtl/ysyx_23060077_rd_arbiter.sv
// Two-master read arbiter serialising whole Icache/LSU read transactions onto one AXI4 read master.
// Define YSYX_23060077_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_23060077_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input logic clock,
    input logic reset,
    ysyx_23060077_rd_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, AR, R} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              grant_lsu_q;
    logic              err_q;
    logic              any_req;
    logic              pick_lsu;
    logic              beat;
    logic [DATA_W-1:0] rdata;

    assign any_req = bus.icache_r_valid_i | bus.lsu_r_valid_i;
    assign beat    = (state_q == R) & bus.axi_rvalid_i;
    assign rdata   = bus.axi_rdata_i;

`ifdef YSYX_23060077_ARB_RR_EN
    // last_lsu_q: the previous grant went to the LSU, so the Icache wins the next collision
    logic last_lsu_q;
    assign pick_lsu = bus.lsu_r_valid_i & (~bus.icache_r_valid_i | ~last_lsu_q);
`else
    assign pick_lsu = bus.lsu_r_valid_i;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        bus.axi_arvalid_o    = 1'b0;
        bus.axi_rready_o     = 1'b0;
        bus.icache_r_ready_o = 1'b0;
        bus.icache_r_last_o  = 1'b0;
        bus.lsu_r_ready_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = AR;
            end
            AR: begin
                bus.axi_arvalid_o = 1'b1;
                if (bus.axi_arready_i) state_d = R;
            end
            R: begin
                bus.axi_rready_o     = 1'b1;
                bus.icache_r_ready_o = beat & ~grant_lsu_q;
                bus.icache_r_last_o  = beat & ~grant_lsu_q & bus.axi_rlast_i;
                bus.lsu_r_ready_o    = beat & grant_lsu_q;
                // Only rlast ends the burst, even when the beat count disagrees
                if (beat && bus.axi_rlast_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            grant_lsu_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef YSYX_23060077_ARB_RR_EN
            last_lsu_q  <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && any_req) begin
                grant_lsu_q <= pick_lsu;
                addr_q      <= pick_lsu ? bus.lsu_r_addr_i : bus.icache_r_addr_i;
                len_q       <= pick_lsu ? '0 : bus.icache_r_len_i;
                cnt_q       <= '0;
`ifdef YSYX_23060077_ARB_RR_EN
                last_lsu_q  <= pick_lsu;
`endif
            end
            if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                // cnt_q indexes the current beat: rlast must coincide with index == len
                if (bus.axi_rresp_i != 2'b00) err_q <= 1'b1;
                if (bus.axi_rlast_i != (cnt_q == len_q)) err_q <= 1'b1;
            end
        end
    end

    assign bus.axi_araddr_o    = addr_q;
    assign bus.axi_arlen_o     = len_q;
    assign bus.axi_arsize_o    = 3'b010;
    assign bus.axi_arburst_o   = 2'b01;
    assign bus.icache_r_data_o = rdata;
    assign bus.lsu_r_data_o    = rdata;
    assign bus.rd_err_o        = err_q;
endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Self-checking bench for the two-master read arbiter: AXI slave driven from tasks,
// expected beats queued at stimulus time and popped when the arbiter hands data to a master.
module tb_ysyx_23060077_rd_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    ysyx_23060077_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    ysyx_23060077_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // {icache ready, icache last, lsu ready, data} as the granted master should see it
    function automatic logic [34:0] exp_vec(input beat_t e);
        return {~e.lsu, ~e.lsu & e.last, e.lsu, e.data};
    endfunction

    // Waits (bounded) for arvalid, holds arready low for 'delay' cycles, then handshakes.
    task automatic do_ar(input int delay, output logic [31:0] addr, output logic [7:0] len,
                         output int waited, output bit stable);
        waited = 0;
        stable = 1'b1;
        while (!bus.axi_arvalid_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        addr = bus.axi_araddr_o;
        len  = bus.axi_arlen_o;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!bus.axi_arvalid_o || bus.axi_araddr_o !== addr || bus.axi_arlen_o !== len
                || bus.axi_rready_o !== 1'b0) stable = 1'b0;
        end
        bus.axi_arready_i = 1'b1;
        @(negedge clk);
        bus.axi_arready_i = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                           output logic [34:0] o);
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rdata_i  = d;
        bus.axi_rresp_i  = resp;
        bus.axi_rlast_i  = last;
        #1;
        o = {bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o,
             bus.lsu_r_ready_o ? bus.lsu_r_data_o : bus.icache_r_data_o};
        @(negedge clk);
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_rresp_i  = 2'b00;
    endtask

    task automatic test_reset();
        checks++; if (bus.axi_arvalid_o !== 1'b0 || bus.axi_rready_o !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got arvalid=%b rready=%b want 0 0", bus.axi_arvalid_o, bus.axi_rready_o); end
        checks++; if ({bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b want 000", {bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o}); end
        checks++; if (bus.rd_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", bus.rd_err_o); end
        checks++; if ({bus.axi_araddr_o, bus.axi_arlen_o} !== 40'h0) begin
            errors++; $display("FAIL reset_addr_len: got %h want 0", {bus.axi_araddr_o, bus.axi_arlen_o}); end
        checks++; if ({bus.axi_arsize_o, bus.axi_arburst_o} !== 5'b010_01) begin
            errors++; $display("FAIL ar_consts: got %b want 01001", {bus.axi_arsize_o, bus.axi_arburst_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.axi_arvalid_o !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: got arvalid=%b want 0", bus.axi_arvalid_o); end
    endtask

    task automatic test_icache_burst();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        bus.icache_r_valid_i = 1'b1;
        bus.icache_r_addr_i  = 32'h3000_0000;
        bus.icache_r_len_i   = 8'd3;
        do_ar(0, a, l, w, st);
        checks++; if (w !== 1) begin errors++; $display("FAIL burst_ar_latency: got %0d want 1", w); end
        checks++; if ({a, l} !== {32'h3000_0000, 8'd3}) begin
            errors++; $display("FAIL burst_ar: got %h/%0d want 30000000/3", a, l); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{lsu: 1'b0, data: 32'hA0 + i, last: (i == 3)});
            do_beat(32'hA0 + i, 2'b00, i == 3, o);
            e = exp_q.pop_front();
            checks++; if (o !== exp_vec(e)) begin
                errors++; $display("FAIL burst_beat%0d: got %h want %h", i, o, exp_vec(e)); end
        end
        bus.icache_r_valid_i = 1'b0;
        checks++; if (bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL burst_err: got %b want 0", bus.rd_err_o); end
    endtask

    task automatic test_collision();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        logic [31:0] ea[3]; logic [7:0] el[3]; bit elsu[3]; int nb;
        ea[0] = 32'h8000_0100; el[0] = 8'd0; elsu[0] = 1'b1;
`ifdef YSYX_23060077_ARB_RR_EN
        ea[1] = 32'h3000_0040; el[1] = 8'd1; elsu[1] = 1'b0;
        ea[2] = 32'h8000_0200; el[2] = 8'd0; elsu[2] = 1'b1;
`else
        ea[1] = 32'h8000_0200; el[1] = 8'd0; elsu[1] = 1'b1;
        ea[2] = 32'h3000_0040; el[2] = 8'd1; elsu[2] = 1'b0;
`endif
        bus.icache_r_valid_i = 1'b1; bus.icache_r_addr_i = 32'h3000_0040; bus.icache_r_len_i = 8'd1;
        bus.lsu_r_valid_i    = 1'b1; bus.lsu_r_addr_i    = 32'h8000_0100;
        for (int g = 0; g < 3; g++) begin
            do_ar(0, a, l, w, st);
            checks++; if (w !== 1) begin errors++; $display("FAIL coll_latency%0d: got %0d want 1", g, w); end
            checks++; if ({a, l} !== {ea[g], el[g]}) begin
                errors++; $display("FAIL coll_grant%0d: got %h/%0d want %h/%0d", g, a, l, ea[g], el[g]); end
            nb = elsu[g] ? 1 : 2;
            for (int b = 0; b < nb; b++) begin
                exp_q.push_back('{lsu: elsu[g], data: 32'hD000_0000 + g * 16 + b, last: (b == nb - 1)});
                do_beat(32'hD000_0000 + g * 16 + b, 2'b00, b == nb - 1, o);
                e = exp_q.pop_front();
                checks++; if (o !== exp_vec(e)) begin
                    errors++; $display("FAIL coll_beat%0d_%0d: got %h want %h", g, b, o, exp_vec(e)); end
            end
            // The LSU re-requests at once after its first read to force a second collision
            if (elsu[g] && ea[g] == 32'h8000_0100) bus.lsu_r_addr_i = 32'h8000_0200;
            else if (elsu[g]) bus.lsu_r_valid_i = 1'b0;
            else bus.icache_r_valid_i = 1'b0;
        end
    endtask

    task automatic test_arready_delay();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        bus.lsu_r_valid_i = 1'b1;
        bus.lsu_r_addr_i  = 32'h8000_0300;
        do_ar(5, a, l, w, st);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL ar_hold: got stable=%b want 1", st); end
        checks++; if ({a, l} !== {32'h8000_0300, 8'd0}) begin
            errors++; $display("FAIL ar_delay_addr: got %h/%0d want 80000300/0", a, l); end
        checks++; if (bus.axi_rready_o !== 1'b1) begin
            errors++; $display("FAIL rready_after_hs: got %b want 1", bus.axi_rready_o); end
        exp_q.push_back('{lsu: 1'b1, data: 32'h5555_AAAA, last: 1'b1});
        do_beat(32'h5555_AAAA, 2'b00, 1'b1, o);
        e = exp_q.pop_front();
        checks++; if (o !== exp_vec(e)) begin errors++; $display("FAIL ar_delay_beat: got %h want %h", o, exp_vec(e)); end
        bus.lsu_r_valid_i = 1'b0;
    endtask

    task automatic test_rvalid_gaps();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e; int n;
        bus.icache_r_valid_i = 1'b1; bus.icache_r_addr_i = 32'h3000_0080; bus.icache_r_len_i = 8'd3;
        do_ar(0, a, l, w, st);
        checks++; if ({a, l} !== {32'h3000_0080, 8'd3}) begin
            errors++; $display("FAIL gaps_ar: got %h/%0d want 30000080/3", a, l); end
        n = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 1 || c == 4 || c == 5 || c == 9) begin
                exp_q.push_back('{lsu: 1'b0, data: 32'hB0 + n, last: (n == 3)});
                do_beat(32'hB0 + n, 2'b00, n == 3, o);
                e = exp_q.pop_front();
                checks++; if (o !== exp_vec(e)) begin
                    errors++; $display("FAIL gaps_beat_c%0d: got %h want %h", c, o, exp_vec(e)); end
                n++;
            end else begin
                #1;
                checks++; if ({bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o} !== 3'b000) begin
                    errors++; $display("FAIL gaps_idle_c%0d: got %b want 000", c,
                                       {bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o}); end
                @(negedge clk);
            end
        end
        bus.icache_r_valid_i = 1'b0;
        checks++; if (bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL gaps_err: got %b want 0", bus.rd_err_o); end
    endtask

    task automatic test_rresp_err();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        bus.icache_r_valid_i = 1'b1; bus.icache_r_addr_i = 32'h3000_0100; bus.icache_r_len_i = 8'd3;
        do_ar(0, a, l, w, st);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{lsu: 1'b0, data: 32'hC0 + i, last: (i == 3)});
            do_beat(32'hC0 + i, (i == 1) ? 2'b10 : 2'b00, i == 3, o);
            e = exp_q.pop_front();
            checks++; if (o !== exp_vec(e)) begin
                errors++; $display("FAIL rresp_beat%0d: got %h want %h", i, o, exp_vec(e)); end
            if (i == 0) begin
                checks++; if (bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL rresp_early: got %b want 0", bus.rd_err_o); end
            end
        end
        bus.icache_r_valid_i = 1'b0;
        checks++; if (bus.rd_err_o !== 1'b1) begin errors++; $display("FAIL rresp_err: got %b want 1", bus.rd_err_o); end
    endtask

    task automatic test_rlast_err();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        #2; rst_n = 1'b0; #1;
        checks++; if (bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", bus.rd_err_o); end
        @(negedge clk); rst_n = 1'b1;
        bus.icache_r_valid_i = 1'b1; bus.icache_r_addr_i = 32'h3000_0200; bus.icache_r_len_i = 8'd3;
        do_ar(0, a, l, w, st);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{lsu: 1'b0, data: 32'hE0 + i, last: (i == 1)});
            do_beat(32'hE0 + i, 2'b00, i == 1, o);
            e = exp_q.pop_front();
            checks++; if (o !== exp_vec(e)) begin
                errors++; $display("FAIL rlast_beat%0d: got %h want %h", i, o, exp_vec(e)); end
        end
        bus.icache_r_valid_i = 1'b0;
        checks++; if (bus.rd_err_o !== 1'b1) begin errors++; $display("FAIL rlast_err: got %b want 1", bus.rd_err_o); end
        checks++; if ({bus.axi_rready_o, bus.axi_arvalid_o} !== 2'b00) begin
            errors++; $display("FAIL rlast_idle: got rready/arvalid=%b want 00", {bus.axi_rready_o, bus.axi_arvalid_o}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a; logic [7:0] l; int w; bit st; logic [34:0] o; beat_t e;
        bus.icache_r_valid_i = 1'b1; bus.icache_r_addr_i = 32'h3000_0300; bus.icache_r_len_i = 8'd3;
        do_ar(0, a, l, w, st);
        exp_q.push_back('{lsu: 1'b0, data: 32'hF0, last: 1'b0});
        do_beat(32'hF0, 2'b00, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o !== exp_vec(e)) begin errors++; $display("FAIL rstmid_beat: got %h want %h", o, exp_vec(e)); end
        bus.axi_rvalid_i = 1'b1; bus.axi_rdata_i = 32'hF1;
        #1;
        checks++; if (bus.icache_r_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus.icache_r_ready_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.axi_arvalid_o, bus.axi_rready_o, bus.icache_r_ready_o, bus.icache_r_last_o,
                       bus.lsu_r_ready_o, bus.rd_err_o} !== 6'b0) begin
            errors++; $display("FAIL rstmid_outputs: got %b want 000000", {bus.axi_arvalid_o, bus.axi_rready_o,
                               bus.icache_r_ready_o, bus.icache_r_last_o, bus.lsu_r_ready_o, bus.rd_err_o}); end
        checks++; if ({bus.axi_araddr_o, bus.axi_arlen_o} !== 40'h0) begin
            errors++; $display("FAIL rstmid_regs: got %h want 0", {bus.axi_araddr_o, bus.axi_arlen_o}); end
        bus.axi_rvalid_i = 1'b0; bus.icache_r_valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if ({bus.axi_arvalid_o, bus.axi_rready_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid_idle: got %b want 00", {bus.axi_arvalid_o, bus.axi_rready_o}); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0;
        bus.icache_r_valid_i = 1'b0; bus.icache_r_addr_i = '0; bus.icache_r_len_i = '0;
        bus.lsu_r_valid_i = 1'b0; bus.lsu_r_addr_i = '0;
        bus.axi_arready_i = 1'b0; bus.axi_rvalid_i = 1'b0; bus.axi_rdata_i = '0;
        bus.axi_rresp_i = 2'b00; bus.axi_rlast_i = 1'b0;
        #2;
        test_reset();
        test_icache_burst();
        test_collision();
        test_arready_delay();
        test_rvalid_gaps();
        test_rresp_err();
        test_rlast_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
